// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock, WIDTH+1 steps per
// multiply, with a run-time choice of signed or unsigned operands.
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int E  = WIDTH + 1;
    localparam int CW = $clog2(E + 1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t             state_q, state_d;
    logic [E-1:0]       m_q, m_d;
    logic [E:0]         acc_q, acc_d;
    logic [E-1:0]       q_q, q_d;
    logic               q1_q, q1_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               done_q, done_d;

    logic [E:0]         m_ext;
    logic [E:0]         sum;
    logic [2*E+1:0]     shifted;
    logic               last_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    // Booth add/subtract followed by the arithmetic right shift of {ACC,Q,q_1}.
    always_comb begin
        m_ext = {m_q[E-1], m_q};
        case ({q_q[0], q1_q})
            2'b01:   sum = acc_q + m_ext;
            2'b10:   sum = acc_q - m_ext;
            default: sum = acc_q;
        endcase
        shifted   = {sum[E], sum, q_q};
        last_step = (cnt_q == CW'(E - 1));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (last_step) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        q1_d      = q1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                m_d   = signed_mode ? {op_a[WIDTH-1], op_a} : {1'b0, op_a};
                q_d   = signed_mode ? {op_b[WIDTH-1], op_b} : {1'b0, op_b};
                acc_d = '0;
                q1_d  = 1'b0;
                cnt_d = '0;
            end
        end else begin
            acc_d = shifted[2*E+1:E+1];
            q_d   = shifted[E:1];
            q1_d  = shifted[0];
            cnt_d = cnt_q + 1'b1;
            if (last_step) begin
                product_d = shifted[2*WIDTH:1];
                done_d    = 1'b1;
            end
        end
    end

    always_comb begin
        busy = (state_q == CALC);
    end

    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq: WIDTH=8 scenarios plus an exhaustive WIDTH=4 sweep.
module tb_booth_mult_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start8, sm8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] prod8;
    logic        start4, sm4;
    logic [3:0]  a4, b4;
    logic        busy4, done4;
    logic [7:0]  prod4;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .op_a(a8), .op_b(b8), .busy(busy8), .done(done8), .product(prod8)
    );

    booth_mult_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
        .op_a(a4), .op_b(b4), .busy(busy4), .done(done4), .product(prod4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_8(input logic [7:0] a, input logic [7:0] b, input logic sm);
        a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
        tick();
        start8 = 1'b0;
    endtask

    // Counts edges until done (bounded) and the number of busy samples on the way.
    task automatic wait_done8(output int cyc, output int nb);
        cyc = 0; nb = 0;
        while (done8 !== 1'b1 && cyc < 40) begin
            if (busy8 === 1'b1) nb++;
            tick();
            cyc++;
        end
    endtask

    task automatic mult8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                         input logic [15:0] exp, input string tag);
        int cyc, nb;
        start_8(a, b, sm);
        wait_done8(cyc, nb);
        $display("txn %s: a=%0h b=%0h sm=%0d product=%0h latency=%0d", tag, a, b, sm, prod8, cyc);
        chk({tag, "_lat"}, cyc, 9);
        chk({tag, "_busycnt"}, nb, 9);
        chk({tag, "_prod"}, prod8, exp);
        chk({tag, "_busy_at_done"}, busy8, 0);
        tick();
        chk({tag, "_done_pulse"}, done8, 0);
    endtask

    initial begin
        int cyc, nb, seen, ia, ib, expv;
        rst = 1'b1; start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
        tick(); tick();
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_prod", prod8, 0);
        // Reset wins over a simultaneous start.
        a8 = 8'd5; b8 = 8'd5; start8 = 1'b1;
        tick();
        start8 = 1'b0; rst = 1'b0;
        tick();
        chk("rst_vs_start_busy", busy8, 0);

        mult8(8'd12,  8'd34,  1'b0, 16'd408,  "u12x34");
        mult8(8'd255, 8'd255, 1'b0, 16'hFE01, "u255x255");
        mult8(8'd255, 8'd255, 1'b1, 16'h0001, "s_m1xm1");
        mult8(8'hF9,  8'd5,   1'b1, 16'hFFDD, "s_m7x5");
        mult8(8'h80,  8'h80,  1'b1, 16'h4000, "s_m128xm128");
        mult8(8'd0,   8'h80,  1'b1, 16'h0000, "s_0xm128");

        // Starts at cycles 3 and 5 of a running multiply are ignored.
        start_8(8'd100, 8'd3, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            a8 = 8'd7; b8 = 8'd7; sm8 = 1'b1;
            start8 = (k == 2 || k == 4);
        end
        start8 = 1'b0;
        wait_done8(cyc, nb);
        $display("txn ignored_start: product=%0h remaining=%0d", prod8, cyc);
        chk("ign_remaining", cyc, 3);
        chk("ign_prod", prod8, 16'd300);
        tick();
        chk("ign_no_rerun", busy8, 0);

        // start during the done cycle is accepted; previous product holds meanwhile.
        start_8(8'd12, 8'd34, 1'b0);
        wait_done8(cyc, nb);
        chk("b2b_first", prod8, 16'd408);
        start_8(8'd3, 8'd4, 1'b0);
        chk("b2b_busy", busy8, 1);
        chk("b2b_hold", prod8, 16'd408);
        wait_done8(cyc, nb);
        $display("txn back_to_back: product=%0h latency=%0d", prod8, cyc);
        chk("b2b_lat", cyc, 9);
        chk("b2b_prod", prod8, 16'd12);

        // Reset mid-operation aborts with no done pulse.
        start_8(8'd99, 8'd99, 1'b0);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy8, 0);
        chk("abort_prod", prod8, 0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (done8 === 1'b1) seen = 1;
            tick();
        end
        $display("txn abort: done_seen=%0d", seen);
        chk("abort_no_done", seen, 0);
        mult8(8'd3, 8'd4, 1'b0, 16'd12, "after_abort");

        // Exhaustive WIDTH=4 sweep against an integer reference.
        for (int sm = 0; sm < 2; sm++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    ia = (sm == 1 && a >= 8) ? a - 16 : a;
                    ib = (sm == 1 && b >= 8) ? b - 16 : b;
                    expv = (ia * ib) & 32'hFF;
                    a4 = 4'(a); b4 = 4'(b); sm4 = sm[0]; start4 = 1'b1;
                    tick();
                    start4 = 1'b0;
                    cyc = 0;
                    while (done4 !== 1'b1 && cyc < 20) begin
                        tick();
                        cyc++;
                    end
                    $display("txn w4: a=%0d b=%0d sm=%0d product=%0h latency=%0d", a, b, sm, prod4, cyc);
                    chk("w4_lat", cyc, 5);
                    chk("w4_prod", prod4, expv);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Parametrised sequential radix-2 Booth multiplier core with a start/done handshake and a run-time signed/unsigned mode. It sits inside `module_top`, between the keypad operand-capture logic and the 7-segment display path. It replaces the fixed-width multiplier with one generic in operand width. It retires one Booth step per clock and has a constant, mode-independent latency.

## Interface
- `WIDTH`, default 8: operand width in bits. Legal range is 2 to 32.
- `clk` input, 1 bit: single system clock. All state updates on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: request a multiply. It is sampled only in IDLE.
- `signed_mode` input, 1 bit: 1 treats operands as two's complement, 0 as unsigned. Sampled with `start`.
- `op_a` input, `WIDTH` bits: multiplicand. Sampled with `start`.
- `op_b` input, `WIDTH` bits: multiplier. Sampled with `start`.
- `busy` output, 1 bit: high while a multiply is in progress.
- `done` output, 1 bit: single-cycle pulse when `product` is updated.
- `product` output, 2·`WIDTH` bits: result. Holds its value until the next completion.

## Operation
- Extended width is E = `WIDTH`+1. Operands are sign-extended when `signed_mode`=1 and zero-extended when 0. This lets one E-step signed Booth datapath serve both modes.
- Internal registers:
  - M: E bits, extended `op_a`.
  - ACC: E+1 bits, signed. The extra bit absorbs the intermediate overflow of ACC±M.
  - Q: E bits, extended `op_b`.
  - q_1: 1 bit.
  - step counter: ceil(log2(E+1)) bits.
- States and transitions:
  - IDLE: `start`=1 → load M and Q, set ACC=0, q_1=0, counter=0, and go to CALC. Otherwise stay in IDLE.
  - CALC: one Booth step per cycle.
    - Select on {Q[0],q_1}: 01 → ACC+=M, 10 → ACC−=M, 00/11 → no add.
    - Then arithmetic-shift {ACC,Q,q_1} right by 1, sign from ACC MSB.
    - Increment the counter.
    - On the step where the counter reaches E−1, also load `product` with the low 2·`WIDTH` bits of the shifted {ACC,Q}, set `done`=1, and return to IDLE.
- Arithmetic:
  - Result modulo 2^(2·`WIDTH`).
  - Exact for all unsigned inputs: 0..(2^`WIDTH`−1)².
  - Exact for all signed inputs, including −2^(`WIDTH`−1) × −2^(`WIDTH`−1).
- `busy` = (state==CALC).
- `start` while `busy`=1 is ignored; it is neither queued nor does it corrupt the operation.
- Changes on `op_a`/`op_b`/`signed_mode` after the load edge have no effect on the operation in flight.

## Timing
- Reset values: `busy`=0, `done`=0, `product`=0, state IDLE, all internal registers 0.
- `rst` overrides everything, including a simultaneous `start`.
- Load edge L is the rising edge where `start`=1 in IDLE. `busy` is high from the cycle after L.
- Booth steps occur on edges L+1 … L+E.
- At edge L+E:
  - `product` is updated;
  - `done` goes high for exactly one cycle;
  - `busy` drops.
- Latency from load edge to `done` visible is E = `WIDTH`+1 cycles. Minimum start-to-start spacing is E+1 cycles.
- Back-to-back: `start`=1 in the cycle where `done`=1 is accepted, because the state is already IDLE. The new load occurs at that edge and `product` keeps the previous result until its own completion.
- Reset mid-operation: the operation is aborted, no `done` pulse is produced, and `product` returns to 0 on that edge.
- `done` and `busy` are never high in the same cycle.

## Test plan
- Unsigned, `WIDTH`=8: `op_a`=12, `op_b`=34, `signed_mode`=0 → after 9 cycles `done` pulses once and `product`=16'd408. `busy` is high for exactly 9 cycles.
- Unsigned extreme: 255×255, `signed_mode`=0 → `product`=16'hFE01. Repeat with `signed_mode`=1 on the same bit patterns (−1×−1) → `product`=16'h0001.
- Signed: −7×5 → 16'hFFDD. −128×−128 → 16'h4000. 0×−128 → 16'h0000.
- Handshake:
  - Pulse `start` with new operands at cycles 3 and 5 of a running multiply → both ignored; result matches the original operands.
  - `start` asserted during the `done` cycle → second result arrives exactly 9 cycles later.
- Reset: assert `rst` at step 4 of 99×99 → `busy`=0, `product`=0, no `done` pulse. A following 3×4 yields 16'd12.
- Parameter sweep: `WIDTH`=4, exhaustive 256 operand pairs × both modes against a reference model. `done` latency is 5 cycles for every case.
